instruction_decode: RTL and testbench

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/instruction_decode_pkg.sv | 39 +++
 rtl/instruction_decode_register_file.sv | 33 +++
 rtl/instruction_decode.sv | 149 ++++++++++++++
 tb/tb_instruction_decode.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// rtl/instruction_decode_pkg.sv - opcode patterns, ALU operation codes and control types shared by decode and execute
package instruction_decode_pkg;

    // Opcode field instruction[31:21]; '?' bits are don't-care for casez matching
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_B    = 11'b000101?????;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef struct packed {
        logic       uncondbranch;
        logic       branch;
        logic       mem_read;
        logic       mem2reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_op;
    } ctrl_t;

    // Which immediate field the instruction carries
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_D    = 2'd1,
        IMM_CB   = 2'd2,
        IMM_B    = 2'd3
    } imm_sel_t;

endpackage

// File: rtl/instruction_decode_register_file.sv
// rtl/instruction_decode_register_file.sv - 32 x 64 register file, combinational reads, falling-edge write
// Ports: clk, resetl (async active-low clear), we/wr_addr/wr_data (write-back),
//        rd_addr_a/rd_addr_b -> rd_data_a/rd_data_b (combinational reads, X31 reads 0)
module register_file (
    input  logic        clk,
    input  logic        resetl,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [63:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [63:0] rd_data_a,
    output logic [63:0] rd_data_b
);

    logic [63:0] regs [0:31];

    // Writing on the falling edge lets the ID/EX register sample the new
    // value at the following rising edge without a bypass path.
    always_ff @(negedge clk or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (we && (wr_addr != 5'd31)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == 5'd31) ? 64'd0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd31) ? 64'd0 : regs[rd_addr_b];

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - instruction decode stage: control decode, register read, immediate extend, ID/EX register
// Ports: clk, resetl (async active-low), RegWrite_WB/RD_WB/MemtoRegOut_WB (write-back),
//        instruction_ID/pc_ID (decode input), *_EX (registered ID/EX outputs)
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        resetl,
    input  logic        RegWrite_WB,
    input  logic [4:0]  RD_WB,
    input  logic [63:0] MemtoRegOut_WB,
    input  logic [31:0] instruction_ID,
    input  logic [63:0] pc_ID,
    output logic        RegWrite_EX,
    output logic        ALUSrc_EX,
    output logic        Branch_EX,
    output logic        Uncondbranch_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        Mem2Reg_EX,
    output logic [3:0]  ALUOp_EX,
    output logic [4:0]  RD_EX,
    output logic [63:0] RegOutA_EX,
    output logic [63:0] RegOutB_EX,
    output logic [63:0] SignExtImm64_EX,
    output logic [63:0] pc_EX
);

    logic [10:0] opcode;
    ctrl_t       ctrl;
    imm_sel_t    imm_sel;
    logic        use_rt_b;
    logic [4:0]  rd_addr_b;
    logic [63:0] reg_a;
    logic [63:0] reg_b;
    logic [63:0] imm64;

    assign opcode = instruction_ID[31:21];

    always_comb begin
        ctrl     = '0;
        imm_sel  = IMM_NONE;
        use_rt_b = 1'b0;
        casez (opcode)
            OP_LDUR: begin
                ctrl.mem_read  = 1'b1;
                ctrl.mem2reg   = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm_sel        = IMM_D;
            end
            OP_STUR: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm_sel        = IMM_D;
                use_rt_b       = 1'b1;
            end
            OP_ADD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
            OP_AND: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_AND;
            end
            OP_ORR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ORR;
            end
            OP_CBZ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_PASSB;
                imm_sel     = IMM_CB;
                use_rt_b    = 1'b1;
            end
            OP_B: begin
                ctrl.uncondbranch = 1'b1;
                imm_sel           = IMM_B;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    // STUR and CBZ read their data/test register from the Rt field
    assign rd_addr_b = use_rt_b ? instruction_ID[4:0] : instruction_ID[20:16];

    always_comb begin
        imm64 = 64'd0;
        case (imm_sel)
            IMM_D:   imm64 = {{55{instruction_ID[20]}}, instruction_ID[20:12]};
            IMM_CB:  imm64 = {{45{instruction_ID[23]}}, instruction_ID[23:5]};
            IMM_B:   imm64 = {{38{instruction_ID[25]}}, instruction_ID[25:0]};
            default: imm64 = 64'd0;
        endcase
    end

    register_file u_register_file (
        .clk       (clk),
        .resetl    (resetl),
        .we        (RegWrite_WB),
        .wr_addr   (RD_WB),
        .wr_data   (MemtoRegOut_WB),
        .rd_addr_a (instruction_ID[9:5]),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (reg_a),
        .rd_data_b (reg_b)
    );

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            RegWrite_EX     <= 1'b0;
            ALUSrc_EX       <= 1'b0;
            Branch_EX       <= 1'b0;
            Uncondbranch_EX <= 1'b0;
            MemRead_EX      <= 1'b0;
            MemWrite_EX     <= 1'b0;
            Mem2Reg_EX      <= 1'b0;
            ALUOp_EX        <= 4'd0;
            RD_EX           <= 5'd0;
            RegOutA_EX      <= 64'd0;
            RegOutB_EX      <= 64'd0;
            SignExtImm64_EX <= 64'd0;
            pc_EX           <= 64'd0;
        end else begin
            RegWrite_EX     <= ctrl.reg_write;
            ALUSrc_EX       <= ctrl.alu_src;
            Branch_EX       <= ctrl.branch;
            Uncondbranch_EX <= ctrl.uncondbranch;
            MemRead_EX      <= ctrl.mem_read;
            MemWrite_EX     <= ctrl.mem_write;
            Mem2Reg_EX      <= ctrl.mem2reg;
            ALUOp_EX        <= ctrl.alu_op;
            RD_EX           <= instruction_ID[4:0];
            RegOutA_EX      <= reg_a;
            RegOutB_EX      <= reg_b;
            SignExtImm64_EX <= imm64;
            pc_EX           <= pc_ID;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed-vector self-checking bench for instruction_decode
module tb_instruction_decode;

    logic        clk;
    logic        resetl;
    logic        RegWrite_WB;
    logic [4:0]  RD_WB;
    logic [63:0] MemtoRegOut_WB;
    logic [31:0] instruction_ID;
    logic [63:0] pc_ID;
    logic        RegWrite_EX;
    logic        ALUSrc_EX;
    logic        Branch_EX;
    logic        Uncondbranch_EX;
    logic        MemRead_EX;
    logic        MemWrite_EX;
    logic        Mem2Reg_EX;
    logic [3:0]  ALUOp_EX;
    logic [4:0]  RD_EX;
    logic [63:0] RegOutA_EX;
    logic [63:0] RegOutB_EX;
    logic [63:0] SignExtImm64_EX;
    logic [63:0] pc_EX;

    int n_vec;
    int n_bad;

    // {Uncondbranch,Branch,MemRead,Mem2Reg,MemWrite,ALUSrc,RegWrite,ALUOp}
    logic [10:0]  ctl;
    logic [271:0] ex_bus;
    logic [271:0] exp;

    assign ctl    = {Uncondbranch_EX, Branch_EX, MemRead_EX, Mem2Reg_EX, MemWrite_EX,
                     ALUSrc_EX, RegWrite_EX, ALUOp_EX};
    assign ex_bus = {ctl, RD_EX, RegOutA_EX, RegOutB_EX, SignExtImm64_EX, pc_EX};

    instruction_decode dut (
        .clk             (clk),
        .resetl          (resetl),
        .RegWrite_WB     (RegWrite_WB),
        .RD_WB           (RD_WB),
        .MemtoRegOut_WB  (MemtoRegOut_WB),
        .instruction_ID  (instruction_ID),
        .pc_ID           (pc_ID),
        .RegWrite_EX     (RegWrite_EX),
        .ALUSrc_EX       (ALUSrc_EX),
        .Branch_EX       (Branch_EX),
        .Uncondbranch_EX (Uncondbranch_EX),
        .MemRead_EX      (MemRead_EX),
        .MemWrite_EX     (MemWrite_EX),
        .Mem2Reg_EX      (Mem2Reg_EX),
        .ALUOp_EX        (ALUOp_EX),
        .RD_EX           (RD_EX),
        .RegOutA_EX      (RegOutA_EX),
        .RegOutB_EX      (RegOutB_EX),
        .SignExtImm64_EX (SignExtImm64_EX),
        .pc_EX           (pc_EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction plus write-back, then sample 1 time unit after the capturing edge
    task automatic drive(input logic [31:0] ins, input logic [63:0] pc,
                         input logic we, input logic [4:0] rd, input logic [63:0] data);
        instruction_ID = ins;
        pc_ID          = pc;
        RegWrite_WB    = we;
        RD_WB          = rd;
        MemtoRegOut_WB = data;
        @(posedge clk);
        #1;
        RegWrite_WB = 1'b0;
    endtask

    task automatic test_reset;
        resetl         = 1'b1;
        RegWrite_WB    = 1'b0;
        RD_WB          = 5'd0;
        MemtoRegOut_WB = 64'd0;
        instruction_ID = 32'd0;
        pc_ID          = 64'd0;
        #2 resetl = 1'b0;
        #1;
        n_vec++;
        if (ex_bus !== 272'd0) begin
            n_bad++;
            $display("FAIL reset_initial: got %h expected 0", ex_bus);
        end
        @(posedge clk);
        #3 resetl = 1'b1;
    endtask

    task automatic test_ldur;
        drive(32'hF84003E9, 64'd4, 1'b1, 5'd9, 64'd0);
        exp = {11'b00110110010, 5'd9, 64'd0, 64'd0, 64'd0, 64'd4};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL ldur: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_orr;
        drive(32'hAA1F012A, 64'd8, 1'b0, 5'd0, 64'd0);
        exp = {11'b00000010001, 5'd10, 64'd0, 64'd0, 64'd0, 64'd8};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL orr: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_writeback;
        // X5 written in the same cycle that ADD X1,X5,X5 is decoded
        drive(32'h8B0500A1, 64'h10, 1'b1, 5'd5, 64'h1234);
        exp = {11'b00000010010, 5'd1, 64'h1234, 64'h1234, 64'd0, 64'h10};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL add_wb_x5: got %h expected %h", ex_bus, exp);
        end
        // write to X31 must be dropped; ADD X1,X31,X31
        drive(32'h8B1F03E1, 64'h14, 1'b1, 5'd31, 64'hDEAD);
        exp = {11'b00000010010, 5'd1, 64'd0, 64'd0, 64'd0, 64'h14};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL add_x31: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_cbz;
        drive(32'hB4FFFFE3, 64'h18, 1'b1, 5'd3, 64'hCAFE);
        exp = {11'b01000000111, 5'd3, 64'd0, 64'hCAFE, 64'hFFFFFFFFFFFFFFFF, 64'h18};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL cbz: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_stur;
        // STUR X3,[X5,#-256]
        drive(32'hF81000A3, 64'h1C, 1'b0, 5'd0, 64'd0);
        exp = {11'b00001100010, 5'd3, 64'h1234, 64'hCAFE, 64'hFFFFFFFFFFFFFF00, 64'h1C};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL stur: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_branch;
        drive(32'h14000001, 64'h20, 1'b0, 5'd0, 64'd0);
        exp = {11'b10000000000, 5'd1, 64'd0, 64'd0, 64'd1, 64'h20};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL b_plus1: got %h expected %h", ex_bus, exp);
        end
        drive(32'h17FFFFFF, 64'h24, 1'b0, 5'd0, 64'd0);
        exp = {11'b10000000000, 5'd31, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h24};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL b_minus1: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_alu_misc;
        // SUB X2,X5,X3
        drive(32'hCB0300A2, 64'h28, 1'b0, 5'd0, 64'd0);
        exp = {11'b00000010110, 5'd2, 64'h1234, 64'hCAFE, 64'd0, 64'h28};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL sub: got %h expected %h", ex_bus, exp);
        end
        // AND X2,X5,X3
        drive(32'h8A0300A2, 64'h2C, 1'b0, 5'd0, 64'd0);
        exp = {11'b00000010000, 5'd2, 64'h1234, 64'hCAFE, 64'd0, 64'h2C};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL and: got %h expected %h", ex_bus, exp);
        end
        // unknown opcode: controls and immediate zero, RD still instruction[4:0]
        drive(32'hFFFFFFFF, 64'h30, 1'b0, 5'd0, 64'd0);
        exp = {11'b00000000000, 5'd31, 64'd0, 64'd0, 64'd0, 64'h30};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL unknown_op: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_back_to_back;
        // consecutive writes then reads, one instruction per cycle
        drive(32'h8B0500A1, 64'h34, 1'b1, 5'd7, 64'h7777);
        exp = {11'b00000010010, 5'd1, 64'h1234, 64'h1234, 64'd0, 64'h34};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL b2b_0: got %h expected %h", ex_bus, exp);
        end
        // ADD X4,X7,X3
        drive(32'h8B0300E4, 64'h38, 1'b1, 5'd3, 64'h3333);
        exp = {11'b00000010010, 5'd4, 64'h7777, 64'h3333, 64'd0, 64'h38};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL b2b_1: got %h expected %h", ex_bus, exp);
        end
    endtask

    task automatic test_async_reset;
        #2;
        resetl         = 1'b0;
        RegWrite_WB    = 1'b1;
        RD_WB          = 5'd5;
        MemtoRegOut_WB = 64'h55;
        #1;
        n_vec++;
        if (ex_bus !== 272'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %h expected 0", ex_bus);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        resetl         = 1'b1;
        RegWrite_WB    = 1'b0;
        instruction_ID = 32'h8B0500A1;
        pc_ID          = 64'h40;
        #1;
        n_vec++;
        if (ex_bus !== 272'd0) begin
            n_bad++;
            $display("FAIL reset_release_hold: got %h expected 0", ex_bus);
        end
        @(posedge clk);
        #1;
        exp = {11'b00000010010, 5'd1, 64'd0, 64'd0, 64'd0, 64'h40};
        n_vec++;
        if (ex_bus !== exp) begin
            n_bad++;
            $display("FAIL reset_regs_cleared: got %h expected %h", ex_bus, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_ldur();
        test_orr();
        test_writeback();
        test_cbz();
        test_stur();
        test_branch();
        test_alu_misc();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
